reg_read_port: RTL
==================

// Module: reg_read_port
// PURPOSE
//   Read-side companion to the 16-bit load registers: selects one register of the
//   register bank, samples it into a holding register and presents it to a consumer
//   (ALU operand latch / bus driver) with a valid/ready handshake. One outstanding
//   read at a time; the sampled value stays stable until the consumer accepts it.
// PARAMETERS
//   DATA_W    16  width of each register and of data_out
//   NUM_REGS  8   number of registers present on reg_bank
//   SEL_W     3   width of rd_sel; must satisfy 2**SEL_W >= NUM_REGS
// PORTS
//   clk        in   1                system clock, rising edge
//   rst        in   1                asynchronous, active-high reset
//   reg_bank   in   NUM_REGS*DATA_W  flattened data_out of all registers; reg i = [i*DATA_W +: DATA_W]
//   rd_req     in   1                read request
//   rd_sel     in   SEL_W            register index, qualified by rd_req
//   rd_ready   out  1                port can accept a request this cycle
//   data_out   out  DATA_W           sampled register value
//   out_valid  out  1                data_out holds an unconsumed result
//   out_ready  in   1                consumer accepts data_out this cycle
//   sel_err    out  1                current result came from an out-of-range rd_sel
// BEHAVIOUR
//   - Reset (rst=1, asynchronous): state=IDLE, data_out=0, out_valid=0, sel_err=0, sel_q=0.
//     rd_ready=0 while rst is high. A pending read is discarded; no partial result appears.
//   - States: IDLE, SAMPLE, VALID (registered, binary encoded).
//   - IDLE: rd_ready=1. On rd_req at an edge: sel_q<=rd_sel, go to SAMPLE.
//   - SAMPLE: rd_ready=0. At the next edge: data_out<=reg_bank[sel_q], out_valid<=1,
//     sel_err<=(sel_q>=NUM_REGS). Go to VALID. Out of range: data_out<=0, sel_err<=1.
//   - VALID: out_valid=1; data_out and sel_err held constant. rd_ready=out_ready.
//       out_ready & !rd_req -> IDLE, out_valid<=0 (data_out keeps its last value).
//       out_ready &  rd_req -> sel_q<=rd_sel, out_valid<=0, go to SAMPLE (back-to-back).
//       !out_ready          -> stay; rd_req is ignored (rd_ready=0).
//   - Latency: request accepted at edge k -> out_valid high after edge k+1.
//     Peak throughput is one read per 2 cycles.
//   - Coherence: the sample is taken at edge k+1. A register load committed at edge k
//     (same edge as the accept) is visible in the result. A load at edge k+1 is not.
//   - rd_sel is sampled only at accept; later changes to rd_sel do not affect the result.
//   - rd_ready is combinational from the state and out_ready only; it never depends on rd_req.
//   - Index arithmetic is unsigned; no wrap-around of sel_q onto valid registers.
// CONFIGURATION
//   RD_PARITY_EN defined:
//     - Adds output data_par (1 bit), reset 0.
//     - Loaded with the even-parity bit (^value) of the value captured in SAMPLE.
//     - Held with data_out. Out-of-range reads give data_par=0.
//   RD_PARITY_EN undefined:
//     - data_par does not exist; no parity logic is generated.
//     - All other behaviour is identical.
// TESTING
//   1. rst pulse mid-SAMPLE -> out_valid=0, data_out=0, rd_ready=1 the first cycle after release.
//   2. reg3=16'hA5A5, rd_req,rd_sel=3 at edge k, out_ready=1
//      -> out_valid=1 after edge k+1, data_out=16'hA5A5, sel_err=0.
//   3. reg2 loaded 16'h1234 at the same edge a read of reg2 is accepted
//      -> data_out=16'h1234 (not the old value).
//   4. out_ready=0 for 5 cycles while reg3 changes and rd_req pulses
//      -> data_out stable, no new accept, out_valid stays 1.
//   5. NUM_REGS=6, rd_sel=7 -> data_out=0, sel_err=1. The next read of reg0 clears sel_err.
//   6. Back-to-back reads of reg0..reg7 with out_ready=1 and rd_req held
//      -> 8 results in 16 cycles, in order.
//      With RD_PARITY_EN, 16'h0007 gives data_par=1.

Source files
------------

// File: rtl/reg_read_port.sv
// Read port for the load-register bank: captures one register into a holding
// register and hands it to a consumer over a valid/ready handshake.
// Optional feature: define RD_PARITY_EN to add the even-parity output data_par.
module reg_read_port #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REGS*DATA_W-1:0] reg_bank,
    input  logic                       rd_req,
    input  logic [SEL_W-1:0]           rd_sel,
    output logic                       rd_ready,
    output logic [DATA_W-1:0]          data_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       sel_err
`ifdef RD_PARITY_EN
    ,
    output logic                       data_par
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        VALID  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [SEL_W-1:0]    r_selQ;
    logic [DATA_W-1:0]   r_dataOut;
    logic                r_outValid;
    logic                r_selErr;
    logic                w_canAccept;
    logic                w_accept;
    logic                w_selOor;
    logic [DATA_W-1:0]   w_sampleVal;
`ifdef RD_PARITY_EN
    logic                r_dataPar;
`endif

    // A new request can be taken when idle, or when the held result is consumed this cycle.
    assign w_canAccept = (r_state == IDLE) || ((r_state == VALID) && out_ready);
    assign w_accept    = w_canAccept && rd_req;
    assign rd_ready    = w_canAccept && !rst;

    // Compare one bit wider than sel_q so an index equal to NUM_REGS cannot alias a real register.
    assign w_selOor = ({1'b0, r_selQ} >= (SEL_W+1)'(NUM_REGS));

    always_comb begin
        w_sampleVal = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_selQ == SEL_W'(i)) begin
                w_sampleVal = reg_bank[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (rd_req) begin
                    w_nextState = SAMPLE;
                end
            end
            SAMPLE: begin
                w_nextState = VALID;
            end
            VALID: begin
                if (out_ready) begin
                    w_nextState = rd_req ? SAMPLE : IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Data path: result registers only change in SAMPLE, so they stay stable through any stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_selQ     <= '0;
            r_dataOut  <= '0;
            r_outValid <= 1'b0;
            r_selErr   <= 1'b0;
`ifdef RD_PARITY_EN
            r_dataPar  <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_selQ <= rd_sel;
            end
            if (r_state == SAMPLE) begin
                r_dataOut  <= w_selOor ? '0 : w_sampleVal;
                r_selErr   <= w_selOor;
                r_outValid <= 1'b1;
`ifdef RD_PARITY_EN
                r_dataPar  <= w_selOor ? 1'b0 : ^w_sampleVal;
`endif
            end else if ((r_state == VALID) && out_ready) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign data_out  = r_dataOut;
    assign out_valid = r_outValid;
    assign sel_err   = r_selErr;
`ifdef RD_PARITY_EN
    assign data_par  = r_dataPar;
`endif

endmodule
